// File: rtl/flit_traffic_gen_pkg.sv
// Shared definitions for the flit traffic generator.
//   - Default flit geometry (flit width, node/seq/MSHR field widths).
//   - Header width helper, used by the generator to place the payload.
//   - FSM state encoding (IDLE, WAIT, SEND, GAP, DONE).
//   - Payload LFSR seed and Galois feedback mask.
package flit_traffic_gen_pkg;

    localparam int TGEN_FLIT_W = 144;
    localparam int TGEN_NODE_W = 4;
    localparam int TGEN_SEQ_W  = 3;
    localparam int TGEN_MSHR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_SEND = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } tgen_state_e;

    // Seed loaded at reset and on every run start.
    localparam logic [31:0] TGEN_LFSR_SEED = 32'hACE1ACE1;
    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form.
    localparam logic [31:0] TGEN_LFSR_MASK = 32'h80200003;

    // Header layout, LSB first: dest, src, seq, valid, mshr.
    function automatic int hdr_width(input int node_w, input int seq_w, input int mshr_w);
        return 2 * node_w + seq_w + 1 + mshr_w;
    endfunction

endpackage

// File: rtl/flit_traffic_gen_if.sv
// Router-side flit bus of one node.
//   inj_flit  : flit presented to the router injection port (master drives)
//   inj_ready : router can take an injection this cycle
//   inj_ack   : router consumed inj_flit at this edge
//   ej_flit   : flit ejected by the router at this node
// master = traffic generator, slave = router (or testbench acting as one).
interface flit_traffic_gen_if
    import flit_traffic_gen_pkg::*;
#(
    parameter int FLIT_W = TGEN_FLIT_W
);
    logic [FLIT_W-1:0] inj_flit;
    logic              inj_ready;
    logic              inj_ack;
    logic [FLIT_W-1:0] ej_flit;

    modport master (output inj_flit, input inj_ready, input inj_ack, input ej_flit);
    modport slave  (input inj_flit, output inj_ready, output inj_ack, output ej_flit);
endinterface

// File: rtl/tgen_lfsr32.sv
// 32-bit Galois LFSR used as a payload source by traffic generators.
//   clk, rst : clock, asynchronous active-high reset (reset value = seed constant)
//   load     : load 'seed' (has priority over step)
//   step     : advance one position
//   seed     : value loaded by 'load'
//   q        : current LFSR value
module tgen_lfsr32
    import flit_traffic_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] q
);
    logic [31:0] lfsr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= TGEN_LFSR_SEED;
        end else if (load) begin
            lfsr_reg <= seed;
        end else if (step) begin
            lfsr_reg <= {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? TGEN_LFSR_MASK : 32'h0);
        end
    end

    assign q = lfsr_reg;
endmodule

// File: rtl/flit_traffic_gen.sv
// Programmable flit source/sink for one bufferless-router node.
// Injects PKT_COUNT header-formatted flits under a ready/ack handshake and
// counts/checks flits ejected at this node.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a run (sampled in IDLE or DONE)
//   inj        : router bus (inj_flit out; inj_ready, inj_ack, ej_flit in)
//   sent_cnt   : accepted injections in the current run (saturating)
//   recv_cnt   : valid ejections since reset (saturating)
//   err        : sticky, an ejected flit carried a foreign destination
//   done       : run complete
//   cycle_cnt  : run length in cycles when built with TGEN_CYCLE_CNT_EN,
//                otherwise constant 0
module flit_traffic_gen
    import flit_traffic_gen_pkg::*;
#(
    parameter int FLIT_W    = TGEN_FLIT_W,
    parameter int NODE_W    = TGEN_NODE_W,
    parameter int SEQ_W     = TGEN_SEQ_W,
    parameter int MSHR_W    = TGEN_MSHR_W,
    parameter int NUM_NODES = 16,
    parameter int SRC_ID    = 5,
    parameter int PKT_COUNT = 16,
    parameter int GAP       = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    flit_traffic_gen_if.master        inj,
    output logic [15:0]               sent_cnt,
    output logic [15:0]               recv_cnt,
    output logic                      err,
    output logic                      done,
    output logic [31:0]               cycle_cnt
);
    localparam int HDR_W     = hdr_width(NODE_W, SEQ_W, MSHR_W);
    localparam int PAY_W     = FLIT_W - HDR_W;
    localparam int DEST_LSB  = 0;
    localparam int SRC_LSB   = NODE_W;
    localparam int SEQ_LSB   = 2 * NODE_W;
    localparam int VALID_BIT = 2 * NODE_W + SEQ_W;
    localparam int MSHR_LSB  = VALID_BIT + 1;
    localparam int REP_N     = (PAY_W + 31) / 32;

    localparam logic [NODE_W-1:0] SRC_NODE  = NODE_W'(SRC_ID);
    localparam logic [NODE_W-1:0] DEST_INIT = NODE_W'((SRC_ID + 1) % NUM_NODES);
    localparam logic [NODE_W:0]   NODES_L   = (NODE_W + 1)'(NUM_NODES);
    localparam logic [16:0]       PKT_LAST  = 17'(PKT_COUNT);
    localparam logic [15:0]       GAP_LOAD  = 16'(GAP - 1);

    tgen_state_e         state_reg, state_next;
    logic [FLIT_W-1:0]   inj_flit_reg, flit_next;
    logic [15:0]         sent_cnt_reg, recv_cnt_reg, gap_cnt_reg;
    logic [NODE_W-1:0]   dest_reg;
    logic                err_reg;
    logic                load_flit, accept, start_take, last_flit;
    logic [31:0]         lfsr_q;

    // Next destination: +1 mod NUM_NODES, never addressing ourselves.
    function automatic logic [NODE_W-1:0] dest_step(input logic [NODE_W-1:0] d);
        logic [NODE_W:0] n;
        n = {1'b0, d} + 1'b1;
        if (n >= NODES_L) n = '0;
        if (n[NODE_W-1:0] == SRC_NODE) begin
            n = n + 1'b1;
            if (n >= NODES_L) n = '0;
        end
        return n[NODE_W-1:0];
    endfunction

    tgen_lfsr32 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (start_take),
        .step (accept),
        .seed (TGEN_LFSR_SEED),
        .q    (lfsr_q)
    );

    // A start that goes straight to SEND loads the first flit in the same
    // edge that reinitialises the run, so build it from the initial values.
    logic [15:0]       cur_sent;
    logic [NODE_W-1:0] cur_dest;
    logic [31:0]       cur_lfsr;
    logic [REP_N*32-1:0] pay_rep;

    assign cur_sent = start_take ? 16'h0 : sent_cnt_reg;
    assign cur_dest = start_take ? DEST_INIT : dest_reg;
    assign cur_lfsr = start_take ? TGEN_LFSR_SEED : lfsr_q;

    for (genvar gi = 0; gi < REP_N; gi++) begin : g_rep
        assign pay_rep[gi*32 +: 32] = cur_lfsr;
    end

    always_comb begin
        flit_next = '0;
        flit_next[DEST_LSB +: NODE_W] = cur_dest;
        flit_next[SRC_LSB  +: NODE_W] = SRC_NODE;
        flit_next[SEQ_LSB  +: SEQ_W]  = cur_sent[SEQ_W-1:0];
        flit_next[VALID_BIT]          = 1'b1;
        flit_next[MSHR_LSB +: MSHR_W] = cur_sent[MSHR_W-1:0];
        flit_next[FLIT_W-1:HDR_W]     = pay_rep[PAY_W-1:0];
    end

    assign last_flit = ({1'b0, sent_cnt_reg} + 17'd1) >= PKT_LAST;

    always_comb begin
        state_next = state_reg;
        load_flit  = 1'b0;
        accept     = 1'b0;
        start_take = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_take = 1'b1;
                    if (PKT_COUNT == 0) begin
                        state_next = ST_DONE;
                    end else if (inj.inj_ready) begin
                        state_next = ST_SEND;
                        load_flit  = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (inj.inj_ready) begin
                    state_next = ST_SEND;
                    load_flit  = 1'b1;
                end
            end
            ST_SEND: begin
                if (inj.inj_ack) begin
                    accept = 1'b1;
                    if (last_flit)    state_next = ST_DONE;
                    else if (GAP > 0) state_next = ST_GAP;
                    else              state_next = ST_WAIT;
                end
            end
            ST_GAP: begin
                // The last gap cycle doubles as the wait cycle, so exactly
                // GAP idle cycles separate two flits while inj_ready is high.
                if (gap_cnt_reg == 16'h0) begin
                    if (inj.inj_ready) begin
                        state_next = ST_SEND;
                        load_flit  = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            inj_flit_reg <= '0;
            sent_cnt_reg <= 16'h0;
            dest_reg     <= DEST_INIT;
            gap_cnt_reg  <= 16'h0;
        end else begin
            state_reg <= state_next;
            if (load_flit)   inj_flit_reg <= flit_next;
            else if (accept) inj_flit_reg <= '0;
            if (start_take) begin
                sent_cnt_reg <= 16'h0;
                dest_reg     <= DEST_INIT;
            end else if (accept) begin
                if (sent_cnt_reg != 16'hFFFF) sent_cnt_reg <= sent_cnt_reg + 16'd1;
                dest_reg <= dest_step(dest_reg);
            end
            if (accept)                                            gap_cnt_reg <= GAP_LOAD;
            else if (state_reg == ST_GAP && gap_cnt_reg != 16'h0)  gap_cnt_reg <= gap_cnt_reg - 16'd1;
        end
    end

    // Ejection checker runs in every state and survives run restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            recv_cnt_reg <= 16'h0;
            err_reg      <= 1'b0;
        end else if (inj.ej_flit[VALID_BIT]) begin
            if (recv_cnt_reg != 16'hFFFF) recv_cnt_reg <= recv_cnt_reg + 16'd1;
            if (inj.ej_flit[DEST_LSB +: NODE_W] != SRC_NODE) err_reg <= 1'b1;
        end
    end

`ifdef TGEN_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_reg;

    // The cycle that accepts start counts as the first cycle of the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_reg <= 32'h0;
        end else if (start_take) begin
            cycle_cnt_reg <= (state_next == ST_DONE) ? 32'h0 : 32'h1;
        end else if (state_reg != ST_IDLE && state_reg != ST_DONE &&
                     cycle_cnt_reg != 32'hFFFFFFFF) begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_reg;
`else
    assign cycle_cnt = 32'h0;
`endif

    assign inj.inj_flit = inj_flit_reg;
    assign sent_cnt     = sent_cnt_reg;
    assign recv_cnt     = recv_cnt_reg;
    assign err          = err_reg;
    assign done         = (state_reg == ST_DONE);
endmodule

// File: tb/tb_flit_traffic_gen.sv
// Scoreboard bench for flit_traffic_gen: instance A (defaults, 20 flits)
// gets directed and randomized runs; instance B (GAP=3, 2 flits) checks
// inter-flit spacing. Expected flits/ejection counts are queued at stimulus
// time and compared by a negedge monitor.
module tb_flit_traffic_gen;
    localparam int FW  = 144;
    localparam int SRC = 5;
    localparam int NN  = 16;
    localparam int P1  = 20;

    logic clk = 1'b0;
    logic rst, rst_b, start_a, start_b;
    logic [15:0] sent_a, recv_a, sent_b, recv_b;
    logic err_a, done_a, err_b, done_b;
    logic [31:0] cyc_a, cyc_b;

    always #5 clk = ~clk;

    flit_traffic_gen_if #(.FLIT_W(FW)) bus_a ();
    flit_traffic_gen_if #(.FLIT_W(FW)) bus_b ();

    flit_traffic_gen #(.PKT_COUNT(P1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .inj(bus_a.master),
        .sent_cnt(sent_a), .recv_cnt(recv_a), .err(err_a), .done(done_a), .cycle_cnt(cyc_a));

    flit_traffic_gen #(.PKT_COUNT(2), .GAP(3)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .inj(bus_b.master),
        .sent_cnt(sent_b), .recv_cnt(recv_b), .err(err_b), .done(done_b), .cycle_cnt(cyc_b));

    int checks = 0;
    int failures = 0;
    bit b_finished = 0;

    logic [FW-1:0] exp_q[$];
    int            idx_q[$];
    logic [16:0]   ej_q[$];
    logic [15:0]   recv_m = 16'h0;
    logic          err_m = 1'b0;

    task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: k-th flit of a run built directly from the field rules.
    function automatic logic [FW-1:0] model_flit(input int k);
        int nodes[$];
        logic [31:0] s;
        logic [3:0] d;
        for (int n = 1; n < NN; n++) nodes.push_back((SRC + n) % NN);
        d = 4'(nodes[k % nodes.size()]);
        s = 32'hACE1ACE1;
        for (int i = 0; i < k; i++) s = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
        return {s, s, s, s, 4'(k % 16), 1'b1, 3'(k % 8), 4'(SRC), d};
    endfunction

    task automatic push_run();
        for (int k = 0; k < P1; k++) begin
            exp_q.push_back(model_flit(k));
            idx_q.push_back(k);
        end
    endtask

    task automatic step_a(input bit st, input bit rdy, input bit ack,
                          input bit ej_v, input logic [3:0] ej_d, input bit junk);
        logic [159:0] r;
        logic [FW-1:0] f;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        f = r[FW-1:0];
        f[11]  = ej_v;
        f[3:0] = ej_d;
        if (!ej_v && !junk) f = '0;
        start_a = st;
        bus_a.inj_ready = rdy;
        bus_a.inj_ack = ack;
        bus_a.ej_flit = f;
        if (ej_v) begin
            if (recv_m != 16'hFFFF) recv_m = recv_m + 16'd1;
            if (ej_d != 4'(SRC)) err_m = 1'b1;
            ej_q.push_back({err_m, recv_m});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step_rand(input bit st);
        logic [3:0] d;
        d = ($urandom_range(0, 1) == 0) ? 4'(SRC) : 4'($urandom_range(0, 15));
        step_a(st, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
               $urandom_range(0, 3) == 0, d, 1'($urandom_range(0, 1)));
    endtask

    task automatic run_rand_to_done();
        int n = 0;
        while (!done_a && n < 1500) begin
            step_rand(1'b0);
            n++;
        end
        check("done_a_bound", done_a, 1'b1);
        check("sent_at_done", sent_a, 16'(P1));
    endtask

    // Monitor for instance A.
    int   sent_pend = -1;
    bit   ej_pend = 0, prev_valid = 0, prev_rdy = 0;
    always @(negedge clk) begin
        if (rst) begin
            sent_pend = -1;
            ej_pend = 0;
            prev_valid = 0;
            prev_rdy = 0;
        end else begin
            if (sent_pend >= 0) begin
                check("sent_cnt", sent_a, FW'(sent_pend));
                sent_pend = -1;
            end
            if (ej_pend) begin
                if (ej_q.size() == 0) begin
                    check("ej_scoreboard_empty", 1, 0);
                end else begin
                    logic [16:0] e;
                    e = ej_q.pop_front();
                    check("recv_cnt", recv_a, e[15:0]);
                    check("err", err_a, e[16]);
                end
                ej_pend = 0;
            end
            if (bus_a.ej_flit[11]) ej_pend = 1;
            if (bus_a.inj_flit[11]) begin
                if (!prev_valid) check("rdy_before_flit", prev_rdy, 1'b1);
                if (exp_q.size() == 0) begin
                    check("unexpected_flit", bus_a.inj_flit, '0);
                end else begin
                    check("inj_flit", bus_a.inj_flit, exp_q[0]);
                    if (bus_a.inj_ack) begin
                        void'(exp_q.pop_front());
                        sent_pend = idx_q.pop_front() + 1;
                    end
                end
            end else begin
                check("idle_flit", bus_a.inj_flit, '0);
            end
            prev_valid = bus_a.inj_flit[11];
            prev_rdy = bus_a.inj_ready;
        end
    end

    // Instance B: GAP=3 spacing between two flits, then done.
    initial begin
        int nvalid = 0;
        int zeros = 0;
        bit fin = 0;
        logic [FW-1:0] cur;
        rst_b = 1'b1;
        start_b = 1'b0;
        bus_b.inj_ready = 1'b1;
        bus_b.inj_ack = 1'b1;
        bus_b.ej_flit = '0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            cur = bus_b.inj_flit;
            if (nvalid == 2) begin
                check("b_done", done_b, 1'b1);
                check("b_sent", sent_b, 16'd2);
                check("b_idle_after", cur, '0);
                fin = 1;
            end else if (cur[11]) begin
                check($sformatf("b_flit%0d", nvalid), cur, model_flit(nvalid));
                if (nvalid == 1) check("b_gap_zeros", zeros, 3);
                nvalid++;
            end else if (nvalid == 1) begin
                if (cur == '0) zeros++;
            end
            if (!fin) begin
                @(posedge clk);
                #1;
            end
        end
        if (!fin) check("b_complete", nvalid, 3);
        b_finished = 1;
    end

    initial begin
        logic [FW-1:0] cur;
        int n;
        rst = 1'b1;
        step_a(0, 0, 0, 0, 4'd0, 0);
        step_a(0, 0, 0, 0, 4'd0, 0);
        check("rst_inj", bus_a.inj_flit, '0);
        check("rst_sent", sent_a, 0);
        check("rst_recv", recv_a, 0);
        check("rst_err", err_a, 0);
        check("rst_done", done_a, 0);
        check("rst_cyc", cyc_a, 0);
        rst = 1'b0;

        // Run 1: ready and ack always high; two directed ejections.
        push_run();
        step_a(1, 1, 1, 0, 4'd0, 0);
        cur = bus_a.inj_flit;
        check("first_hdr", cur[15:0], 16'h0856);
        check("first_pay", cur[47:16], 32'hACE1ACE1);
        step_a(0, 1, 1, 1, 4'd5, 0);
        step_a(0, 1, 1, 1, 4'd3, 0);
        cur = bus_a.inj_flit;
        check("second_hdr", cur[15:0], 16'h1957);
        check("ej_recv2", recv_a, 16'd2);
        check("ej_err", err_a, 1'b1);
        n = 0;
        while (!done_a && n < 200) begin
            step_a(0, 1, 1, 0, 4'd0, 0);
            n++;
        end
        check("run1_done", done_a, 1'b1);
        check("run1_sent", sent_a, 16'(P1));
`ifdef TGEN_CYCLE_CNT_EN
        check("run1_cyc", cyc_a, 32'(2 * P1));
`else
        check("run1_cyc", cyc_a, 32'h0);
`endif

        // Run 2: restart from DONE, 5-cycle ack stall, then random handshake.
        push_run();
        step_a(1, 1, 0, 0, 4'd0, 0);
        check("err_kept", err_a, 1'b1);
        check("recv_kept", recv_a, 16'd2);
        for (int i = 0; i < 5; i++) step_a(0, 1, 0, 0, 4'd0, 0);
        check("stall_sent", sent_a, 0);
        check("stall_flit", bus_a.inj_flit, model_flit(0));
        run_rand_to_done();
        check("run2_recv", recv_a, recv_m);

        // Run 3: reset in the middle of a stalled SEND.
        push_run();
        step_a(1, 1, 1, 0, 4'd0, 0);
        step_a(0, 1, 1, 0, 4'd0, 0);
        step_a(0, 1, 0, 0, 4'd0, 0);
        step_a(0, 1, 0, 0, 4'd0, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_inj", bus_a.inj_flit, '0);
        check("mid_rst_sent", sent_a, 0);
        check("mid_rst_recv", recv_a, 0);
        check("mid_rst_err", err_a, 0);
        check("mid_rst_cyc", cyc_a, 0);
        exp_q.delete();
        idx_q.delete();
        ej_q.delete();
        recv_m = 16'h0;
        err_m = 1'b0;
        step_a(0, 0, 0, 0, 4'd0, 0);
        step_a(0, 0, 0, 0, 4'd0, 0);
        rst = 1'b0;

        // Run 4: from IDLE with random handshake and ejections.
        push_run();
        step_rand(1'b1);
        while (!done_a && sent_a == 0 && exp_q.size() == P1 && !bus_a.inj_flit[11] &&
               $urandom_range(0, 1) == 0) step_rand(1'b0);
        if (!done_a && exp_q.size() == P1 && !bus_a.inj_flit[11] && sent_a == 0) begin
            // start may have been taken into WAIT; keep driving until done
        end
        run_rand_to_done();
        check("run4_recv", recv_a, recv_m);
        check("run4_err", err_a, err_m);

        n = 0;
        while (!b_finished && n < 500) begin
            step_a(0, 0, 0, 0, 4'd0, 0);
            n++;
        end
        check("b_finished", b_finished, 1'b1);
        step_a(0, 0, 0, 0, 4'd0, 0);
        step_a(0, 0, 0, 0, 4'd0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
